// File: rtl/move_exec_arbiter_pkg.sv
// Shared chess types for the move execution path: move/board encodings,
// the standard start position and the arbiter state encoding.
package move_exec_arbiter_pkg;

    typedef logic [3:0] piece_t;

    typedef enum logic [1:0] {
        SPECIAL_NONE,
        SPECIAL_CASTLE,
        SPECIAL_EP,
        SPECIAL_PROMO
    } special_t;

    typedef struct packed {
        logic [2:0] src_fil;
        logic [2:0] src_rnk;
        logic [2:0] dst_fil;
        logic [2:0] dst_rnk;
        special_t   special;
    } move_t;

    // Square index is rank*8+file; pieces 1..6 = P,N,B,R,Q,K, bit 3 marks black.
    typedef struct packed {
        logic         stm;
        piece_t [63:0] sq;
    } board_t;

    localparam board_t START_BOARD = '{
        stm: 1'b0,
        sq:  256'hCABEDBAC_99999999_00000000_00000000_00000000_00000000_11111111_42365324
    };

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT
    } arb_state_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/move_exec_arbiter_rr_arbiter.sv
// Round-robin grant: one-hot on the first asserted request at or above ptr,
// wrapping back to index 0.
module rr_arbiter
    import move_exec_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int PTR_W  = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic found;
    int   idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/move_exec_arbiter.sv
// Shares the single move executor between move requesters and owns the
// authoritative board; board loads always win over pending moves.
module move_exec_arbiter
    import move_exec_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  move_t [NUM_REQ-1:0]  req_move_in,
    input  logic  [NUM_REQ-1:0]  req_valid_in,
    output logic  [NUM_REQ-1:0]  req_ready_out,
    input  board_t               load_board_in,
    input  logic                 load_valid_in,
    output logic                 load_ready_out,
    output board_t               exec_board_out,
    output move_t                exec_move_out,
    output logic                 exec_valid_out,
    input  board_t               exec_board_in,
    input  logic                 exec_valid_in,
    output board_t               board_out,
    output logic                 board_valid_out,
    output logic  [NUM_REQ-1:0]  done_out,
    output logic                 timeout_out,
    output logic                 busy_out
);

    localparam int PTR_W = ptr_width(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    arb_state_t          state_reg, state_next;
    board_t              board_reg;
    board_t              exec_board_reg;
    move_t               move_reg;
    logic [PTR_W-1:0]    ptr_reg, ptr_next;
    logic [PTR_W-1:0]    grant_idx_reg, grant_idx;
    logic [CNT_W-1:0]    cnt_reg;
    logic                board_valid_reg;
    logic [NUM_REQ-1:0]  done_reg;
    logic                timeout_reg;

    logic [NUM_REQ-1:0]  rr_grant;
    logic [NUM_REQ-1:0]  ready_vec;
    logic [NUM_REQ-1:0]  done_sel;
    logic                idle;
    logic                accept;
    logic                timeout_hit;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (req_valid_in),
        .ptr   (ptr_reg),
        .grant (rr_grant)
    );

    assign idle        = (state_reg == ARB_IDLE);
    assign ready_vec   = (idle && !load_valid_in) ? rr_grant : '0;
    assign accept      = |ready_vec;
    // A response arriving on the last WAIT cycle takes precedence over abort.
    assign timeout_hit = (state_reg == ARB_WAIT) && !exec_valid_in && (cnt_reg == CNT_LAST);

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rr_grant[i]) grant_idx = PTR_W'(i);
        end
    end

    always_comb begin
        if (int'(grant_idx) == NUM_REQ - 1) ptr_next = '0;
        else                                ptr_next = grant_idx + PTR_W'(1);
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_done_sel
        assign done_sel[gi] = (grant_idx_reg == PTR_W'(gi));
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB_IDLE:  if (accept) state_next = ARB_ISSUE;
            ARB_ISSUE: state_next = ARB_WAIT;
            ARB_WAIT:  if (exec_valid_in || timeout_hit) state_next = ARB_IDLE;
            default:   state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg       <= ARB_IDLE;
            board_reg       <= START_BOARD;
            exec_board_reg  <= START_BOARD;
            move_reg        <= '0;
            ptr_reg         <= '0;
            grant_idx_reg   <= '0;
            cnt_reg         <= '0;
            board_valid_reg <= 1'b0;
            done_reg        <= '0;
            timeout_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            board_valid_reg <= 1'b0;
            done_reg        <= '0;
            timeout_reg     <= 1'b0;
            case (state_reg)
                ARB_IDLE: begin
                    if (load_valid_in) begin
                        board_reg       <= load_board_in;
                        board_valid_reg <= 1'b1;
                    end else if (accept) begin
                        move_reg       <= req_move_in[grant_idx];
                        grant_idx_reg  <= grant_idx;
                        ptr_reg        <= ptr_next;
                        exec_board_reg <= board_reg;
                    end
                end
                ARB_ISSUE: cnt_reg <= '0;
                ARB_WAIT: begin
                    if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + CNT_W'(1);
                    if (exec_valid_in) begin
                        board_reg       <= exec_board_in;
                        board_valid_reg <= 1'b1;
                        done_reg        <= done_sel;
                    end else if (timeout_hit) begin
                        timeout_reg <= 1'b1;
                        done_reg    <= done_sel;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready_out   = ready_vec;
    assign load_ready_out  = idle;
    assign exec_valid_out  = (state_reg == ARB_ISSUE);
    assign exec_board_out  = exec_board_reg;
    assign exec_move_out   = move_reg;
    assign board_out       = board_reg;
    assign board_valid_out = board_valid_reg;
    assign done_out        = done_reg;
    assign timeout_out     = timeout_reg;
    assign busy_out        = !idle;

endmodule

// File: tb/tb_move_exec_arbiter.sv
// Scoreboard bench for move_exec_arbiter: stimulus queues expected issues and
// completions, a monitor pops and compares them whenever the DUT reports.
module tb_move_exec_arbiter;
    import move_exec_arbiter_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int TIMEOUT = 8;
    localparam int M_NORMAL = 0;
    localparam int M_TMO    = 1;
    localparam int M_NONE   = 2;

    logic                clk_in = 1'b0;
    logic                rst_n_in;
    move_t [NUM_REQ-1:0] req_move_in;
    logic  [NUM_REQ-1:0] req_valid_in;
    logic  [NUM_REQ-1:0] req_ready_out;
    board_t              load_board_in;
    logic                load_valid_in;
    logic                load_ready_out;
    board_t              exec_board_out;
    move_t               exec_move_out;
    logic                exec_valid_out;
    board_t              exec_board_in;
    logic                exec_valid_in;
    board_t              board_out;
    logic                board_valid_out;
    logic  [NUM_REQ-1:0] done_out;
    logic                timeout_out;
    logic                busy_out;

    move_exec_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .req_move_in     (req_move_in),
        .req_valid_in    (req_valid_in),
        .req_ready_out   (req_ready_out),
        .load_board_in   (load_board_in),
        .load_valid_in   (load_valid_in),
        .load_ready_out  (load_ready_out),
        .exec_board_out  (exec_board_out),
        .exec_move_out   (exec_move_out),
        .exec_valid_out  (exec_valid_out),
        .exec_board_in   (exec_board_in),
        .exec_valid_in   (exec_valid_in),
        .board_out       (board_out),
        .board_valid_out (board_valid_out),
        .done_out        (done_out),
        .timeout_out     (timeout_out),
        .busy_out        (busy_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        logic [NUM_REQ-1:0] done;
        logic               tmo;
        logic               bv;
        board_t             board;
        int                 cyc;
    } exp_t;

    typedef struct {
        move_t  mv;
        board_t bd;
    } iss_t;

    exp_t   out_q[$];
    iss_t   iss_q[$];
    int     checks = 0;
    int     errors = 0;
    board_t model_board;
    int     exec_lat = 3;
    int     resp_due = -1;
    int     stray_due = -1;
    board_t resp_board;

    task automatic chk(input string name, input logic [263:0] act, input logic [263:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic board_t apply_move(input board_t b, input move_t m);
        board_t r;
        int s, d;
        r = b;
        s = int'(m.src_rnk) * 8 + int'(m.src_fil);
        d = int'(m.dst_rnk) * 8 + int'(m.dst_fil);
        r.sq[d] = b.sq[s];
        r.sq[s] = 4'h0;
        r.stm   = ~b.stm;
        return r;
    endfunction

    function automatic move_t mk_move(input int sf, input int sr, input int df, input int dr);
        move_t m;
        m.src_fil = 3'(sf);
        m.src_rnk = 3'(sr);
        m.dst_fil = 3'(df);
        m.dst_rnk = 3'(dr);
        m.special = SPECIAL_NONE;
        return m;
    endfunction

    // Executor model: answers each issue after exec_lat cycles (0 = silent).
    initial begin
        exec_valid_in = 1'b0;
        exec_board_in = START_BOARD;
        forever begin
            @(negedge clk_in);
            exec_valid_in = (cyc == resp_due) || (cyc == stray_due);
            if (cyc == resp_due)       exec_board_in = resp_board;
            else if (cyc == stray_due) exec_board_in = ~START_BOARD;
            if (exec_valid_out && exec_lat > 0) begin
                resp_due   = cyc + exec_lat;
                resp_board = apply_move(exec_board_out, exec_move_out);
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT issues or reports.
    initial begin
        exp_t e;
        iss_t s;
        forever begin
            @(negedge clk_in);
            #2;
            if (rst_n_in) begin
                if (|req_valid_in)
                    chk("ready_onehot", 264'($countones(req_ready_out) <= 1), 264'(1));
                if (exec_valid_out) begin
                    if (iss_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_issue: got move %h at cycle %0d expected none", exec_move_out, cyc);
                    end else begin
                        s = iss_q.pop_front();
                        chk("issue_move", 264'(exec_move_out), 264'(s.mv));
                        chk("issue_board", 264'(exec_board_out), 264'(s.bd));
                    end
                end
                if (board_valid_out || |done_out || timeout_out) begin
                    if (out_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_event: got done %b timeout %b board_valid %b at cycle %0d expected none",
                                 done_out, timeout_out, board_valid_out, cyc);
                    end else begin
                        e = out_q.pop_front();
                        chk("done", 264'(done_out), 264'(e.done));
                        chk("timeout", 264'(timeout_out), 264'(e.tmo));
                        chk("board_valid", 264'(board_valid_out), 264'(e.bv));
                        chk("board_out", 264'(board_out), 264'(e.board));
                        if (e.cyc >= 0) chk("event_cycle", 264'(cyc), 264'(e.cyc));
                    end
                end
            end
        end
    end

    task automatic push_accept(input int idx, input move_t mv, input int mode, input int hs);
        exp_t e;
        iss_q.push_back('{mv: mv, bd: model_board});
        e.done = NUM_REQ'(1) << idx;
        if (mode == M_NORMAL) begin
            model_board = apply_move(model_board, mv);
            e.tmo = 1'b0; e.bv = 1'b1; e.board = model_board; e.cyc = hs + exec_lat + 2;
            out_q.push_back(e);
        end else if (mode == M_TMO) begin
            e.tmo = 1'b1; e.bv = 1'b0; e.board = model_board; e.cyc = hs + TIMEOUT + 2;
            out_q.push_back(e);
        end
    endtask

    // Called right after a negedge; returns one negedge after the handshake.
    task automatic send(input int idx, input move_t mv, input int mode, output int hs);
        bit ok;
        ok = 1'b0;
        hs = -1;
        for (int n = 0; n < 100 && !ok; n++) begin
            req_move_in[idx]  = mv;
            req_valid_in[idx] = 1'b1;
            #1;
            if (req_ready_out[idx]) begin
                ok = 1'b1;
                hs = cyc;
                push_accept(idx, mv, mode, hs);
            end
            @(negedge clk_in);
        end
        req_valid_in[idx] = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout: req %0d not accepted within 100 cycles", idx);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk_in);
            #3;
            if (!busy_out && out_q.size() == 0) ok = 1'b1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy %b pending %0d after 100 cycles", busy_out, out_q.size());
        end
    endtask

    task automatic do_reset();
        rst_n_in      = 1'b0;
        req_valid_in  = '0;
        load_valid_in = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        model_board = START_BOARD;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int     hs, lcyc;
        int     order[$];
        int     rem[2];
        int     k[2];
        int     exp_order[4];
        move_t  rr_moves[2][2];
        board_t lb;

        rst_n_in      = 1'b0;
        req_valid_in  = '0;
        req_move_in   = '0;
        load_valid_in = 1'b0;
        load_board_in = START_BOARD;
        model_board   = START_BOARD;
        repeat (3) @(negedge clk_in);
        #1;
        chk("rst_board", 264'(board_out), 264'(START_BOARD));
        chk("rst_busy", 264'(busy_out), 264'(0));
        chk("rst_exec_valid", 264'(exec_valid_out), 264'(0));
        chk("rst_pulses", 264'({board_valid_out, done_out, timeout_out}), 264'(0));
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        #1;
        chk("idle_board", 264'(board_out), 264'(START_BOARD));
        chk("idle_busy", 264'(busy_out), 264'(0));
        chk("idle_load_ready", 264'(load_ready_out), 264'(1));
        chk("idle_pulses", 264'({board_valid_out, done_out, timeout_out}), 264'(0));
        @(negedge clk_in);

        // e2e4 from requester 0, executor latency 3
        exec_lat = 3;
        send(0, mk_move(4, 1, 4, 3), M_NORMAL, hs);
        #1;
        chk("issue_latency", 264'(exec_valid_out), 264'(1));
        wait_idle();
        chk("e2e4_board", 264'(board_out), 264'(model_board));

        // Round robin with both requesters valid together
        do_reset();
        rr_moves[0][0] = mk_move(6, 0, 5, 2);
        rr_moves[0][1] = mk_move(1, 0, 2, 2);
        rr_moves[1][0] = mk_move(6, 7, 5, 5);
        rr_moves[1][1] = mk_move(1, 7, 2, 5);
        rem = '{2, 2};
        k   = '{0, 0};
        for (int n = 0; n < 300 && (rem[0] + rem[1]) > 0; n++) begin
            @(negedge clk_in);
            for (int i = 0; i < 2; i++) begin
                req_valid_in[i] = (rem[i] > 0);
                if (rem[i] > 0) req_move_in[i] = rr_moves[i][k[i]];
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                if (req_valid_in[i] && req_ready_out[i]) begin
                    order.push_back(i);
                    push_accept(i, rr_moves[i][k[i]], M_NORMAL, cyc);
                    rem[i]--;
                    k[i]++;
                end
            end
        end
        @(negedge clk_in);
        req_valid_in = '0;
        wait_idle();
        exp_order = '{0, 1, 0, 1};
        chk("rr_grant_count", 264'(order.size()), 264'(4));
        for (int j = 0; j < 4 && j < order.size(); j++)
            chk($sformatf("rr_order_%0d", j), 264'(order[j]), 264'(exp_order[j]));
        chk("rr_board", 264'(board_out), 264'(model_board));

        // Load and req1 in the same cycle: load first, move runs on the loaded board
        lb = START_BOARD;
        lb.sq[12] = 4'h0;
        lb.sq[28] = 4'h1;
        lb.stm    = 1'b1;
        @(negedge clk_in);
        load_board_in   = lb;
        load_valid_in   = 1'b1;
        req_move_in[1]  = mk_move(4, 6, 4, 4);
        req_valid_in[1] = 1'b1;
        #1;
        lcyc = cyc;
        chk("load_ready", 264'(load_ready_out), 264'(1));
        chk("load_blocks_req", 264'(req_ready_out), 264'(0));
        out_q.push_back('{done: '0, tmo: 1'b0, bv: 1'b1, board: lb, cyc: lcyc + 1});
        model_board = lb;
        @(negedge clk_in);
        load_valid_in = 1'b0;
        send(1, mk_move(4, 6, 4, 4), M_NORMAL, hs);
        chk("req_after_load_cycle", 264'(hs), 264'(lcyc + 1));
        wait_idle();
        chk("load_move_board", 264'(board_out), 264'(model_board));

        // Silent executor: abort after TIMEOUT wait cycles, stray response ignored
        exec_lat = 0;
        send(0, mk_move(3, 1, 3, 3), M_TMO, hs);
        stray_due = hs + TIMEOUT + 4;
        wait_idle();
        repeat (6) @(negedge clk_in);
        #3;
        chk("tmo_board_kept", 264'(board_out), 264'(model_board));
        chk("tmo_idle", 264'(busy_out), 264'(0));

        // Response on the terminal wait cycle wins over the timeout
        exec_lat = TIMEOUT;
        send(1, mk_move(3, 6, 3, 4), M_NORMAL, hs);
        wait_idle();
        chk("terminal_board", 264'(board_out), 264'(model_board));

        // Reset mid-WAIT: no completion, late response ignored
        exec_lat = 6;
        send(0, mk_move(0, 1, 0, 2), M_NONE, hs);
        @(negedge clk_in);
        chk("mid_wait_busy", 264'(busy_out), 264'(1));
        rst_n_in = 1'b0;
        #1;
        chk("mid_rst_busy", 264'(busy_out), 264'(0));
        chk("mid_rst_board", 264'(board_out), 264'(START_BOARD));
        chk("mid_rst_done", 264'(done_out), 264'(0));
        repeat (2) @(negedge clk_in);
        rst_n_in    = 1'b1;
        model_board = START_BOARD;
        repeat (10) @(negedge clk_in);
        #3;
        chk("late_resp_board", 264'(board_out), 264'(START_BOARD));
        chk("late_resp_busy", 264'(busy_out), 264'(0));

        chk("outcome_queue_empty", 264'(out_q.size()), 264'(0));
        chk("issue_queue_empty", 264'(iss_q.size()), 264'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/move_exec_arbiter.md
Name: move_exec_arbiter

Overview:
- Owns the single move_executor instance and the authoritative current board register.
- Shares the executor between NUM_REQ move requesters (req 0 = UCI command parser, req 1 = search/bestmove path) using round-robin arbitration. Board loads ("position startpos") take priority over moves.
- Serialises all executor use, so parser and bestmove traffic can never collide on the executor.
- Sits between uci_handler/search and move_executor.

Parameters:
- NUM_REQ, 2, number of move requesters (≥1).
- TIMEOUT, 255, WAIT-state cycles with no executor response before abort (≥1, ≤2^16-1).

Ports:
- clk_in  input  1  clock.
- rst_n_in  input  1  asynchronous active-low reset.
- req_move_in  input  NUM_REQ×move_t  per-requester move.
- req_valid_in  input  NUM_REQ  per-requester valid.
- req_ready_out  output  NUM_REQ  per-requester ready; at most one bit high.
- load_board_in  input  board_t  board to install.
- load_valid_in  input  1  load request.
- load_ready_out  output  1  load accepted when high with load_valid_in.
- exec_board_out  output  board_t  board to executor.
- exec_move_out  output  move_t  move to executor.
- exec_valid_out  output  1  one-cycle issue strobe.
- exec_board_in  input  board_t  executor result.
- exec_valid_in  input  1  executor result valid.
- board_out  output  board_t  current board (registered).
- board_valid_out  output  1  one-cycle pulse when board_out changes.
- done_out  output  NUM_REQ  one-cycle pulse to the requester whose move finished or aborted.
- timeout_out  output  1  one-cycle pulse on abort.
- busy_out  output  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (async, rst_n_in=0):
  - state=IDLE; board_out=START_BOARD; rr pointer=0; wait counter=0.
  - exec_valid_out, board_valid_out, done_out, timeout_out all 0.
  - Reset mid-WAIT abandons the move. No done_out is issued. A late exec_valid_in after reset is ignored.
- States: IDLE, ISSUE, WAIT.
- IDLE, load path:
  - load_ready_out=1 (combinational, IDLE only).
  - On load_valid_in: board_out<=load_board_in, board_valid_out pulses next cycle, state stays IDLE.
  - While load_valid_in=1, all req_ready_out=0.
- IDLE, move path (no load pending):
  - req_ready_out is one-hot on the first requester with valid, searching from the rr pointer upward with wrap.
  - Ready is combinational from req_valid_in. Valid must stay high until accepted.
  - On handshake: latch move and grant index; rr pointer<=grant+1 (mod NUM_REQ); state→ISSUE.
- ISSUE (exactly 1 cycle):
  - exec_valid_out=1; exec_move_out=latched move; exec_board_out=board_out.
  - Counter cleared; state→WAIT.
- WAIT:
  - Counter increments each cycle.
  - On exec_valid_in: board_out<=exec_board_in; board_valid_out and done_out[grant] pulse next cycle; state→IDLE.
  - If counter reaches TIMEOUT with no response: timeout_out and done_out[grant] pulse; board unchanged; state→IDLE.
  - exec_valid_in on the terminal timeout cycle: the response wins and no timeout pulse is issued.
- Latency:
  - Handshake at cycle 0 → exec_valid_out at cycle 1.
  - Response at cycle k → done at k+1.
  - Next request accepted no earlier than cycle k+1.
- exec_valid_in outside WAIT is ignored.
- exec_board_out and exec_move_out hold their values outside ISSUE.
- Width rule: counter is $clog2(TIMEOUT+1) bits, saturating; no wrap.

Decomposition:
- Shared types package gains:
  - START_BOARD localparam board_t, moved out of uci_handler so both blocks share it.
  - arb_state_t enum {ARB_IDLE, ARB_ISSUE, ARB_WAIT}.
- Sub-module rr_arbiter (NUM_REQ param; inputs req, ptr; output one-hot grant) is the one natural split. FSM, board register and counter stay in move_exec_arbiter.

Test Plan:
- Reset then idle → board_out==START_BOARD, busy_out=0, all pulses 0; reassert rst_n_in low mid-WAIT → IDLE at once, no done_out.
- Req0 move e2e4 (src fil4 rnk1, dst fil4 rnk3, SPECIAL_NONE), model executor latency 3 → exec_valid_out at cycle 1, done_out=2'b01 and board_valid_out at cycle 5, board_out equals model result.
- Req0 and req1 valid together, each twice → grant order 0,1,0,1; req_ready_out never has two bits set.
- load_valid_in and req1 valid in the same cycle → load accepted first and board_out updated; req1 accepted the following cycle and executes on the loaded board.
- TIMEOUT=8, executor silent → timeout_out and done_out[grant] pulse 8 cycles after ISSUE, board_out unchanged; a stray exec_valid_in 2 cycles later is ignored.
- exec_valid_in on the exact terminal timeout cycle → board updated, timeout_out stays 0.
